game_flow_controller: RTL and testbench

- Top-level Breakout session sequencer that drives the game-over display and receives its completion signal.
- Tracks lives, serves the ball after a frame-counted delay, and detects ball loss and a cleared board.
- On the last ball lost, it fires trigger_game_over and waits for game_over_complete. It then clears the display and field, and returns to idle.
- Sits between the physics/brick logic and the game-over display.

---
 rtl/game_pkg.sv | 26 ++
 rtl/game_flow_controller_frame_delay_counter.sv | 40 ++++
 rtl/game_flow_controller.sv | 172 +++++++++++++++++
 tb/tb_game_flow_controller.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the Breakout session sequencer.
//   state_e     - session states
//   START_LIVES - default lives loaded at game start / after game over
//   FRAME_RATE  - video frames per second (default serve delay)
//   lives_t     - HUD lives counter type
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SERVE,
    ST_PLAY,
    ST_GAME_OVER,
    ST_CLEANUP
  } state_e;

  localparam int START_LIVES = 3;
  localparam int FRAME_RATE  = 60;
  localparam int LIVES_W     = 2;

  typedef logic [LIVES_W-1:0] lives_t;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/game_flow_controller_frame_delay_counter.sv
// Frame-counted delay shared by the serve delay and the game-over watchdog.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   clear_i      - hold the count at zero
//   frame_tick_i - one-cycle pulse per video frame
//   limit_i      - terminal count (number of frames minus one)
//   done_o       - high in the cycle the terminal frame_tick arrives
module frame_delay_counter #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             frame_tick_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             done_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    done_o  = frame_tick_i && !clear_i && (count_q == limit_i);
    count_d = count_q;
    // Restart on completion so the count never exceeds limit_i.
    if (clear_i || done_o) begin
      count_d = '0;
    end else if (frame_tick_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/game_flow_controller.sv
// Breakout session sequencer: start, serve, play, game-over handshake with
// the display, cleanup.
// Ports:
//   clk, reset          - 50 MHz clock, synchronous active-high reset
//   frame_tick          - one-cycle pulse per video frame
//   start_btn           - debounced button level (rising edge starts a game)
//   ball_lost           - pulse: ball passed the paddle
//   bricks_cleared      - level: board empty
//   game_over_complete  - level from the game-over display
//   play_enable         - high in PLAY
//   serve_ball          - pulse: launch ball
//   lives               - remaining lives
//   trigger_game_over   - pulse: start game-over display
//   game_over_clear     - pulse: return display to idle
//   field_reset         - pulse: reload bricks, zero score
//   in_game_over        - high in GAME_OVER
module game_flow_controller #(
  parameter int START_LIVES        = game_pkg::START_LIVES,
  parameter int SERVE_DELAY_FRAMES = game_pkg::FRAME_RATE,
  parameter int GO_TIMEOUT_FRAMES  = 400
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       ball_lost,
  input  logic       bricks_cleared,
  input  logic       game_over_complete,
  output logic       play_enable,
  output logic       serve_ball,
  output logic [1:0] lives,
  output logic       trigger_game_over,
  output logic       game_over_clear,
  output logic       field_reset,
  output logic       in_game_over
);

  import game_pkg::*;

  localparam int unsigned MAX_FRAMES = max2(SERVE_DELAY_FRAMES, GO_TIMEOUT_FRAMES);
  localparam int CNT_W = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_DELAY_FRAMES - 1);
  localparam logic [CNT_W-1:0] GO_LAST    = CNT_W'(GO_TIMEOUT_FRAMES - 1);
  localparam lives_t LIVES_INIT = lives_t'(START_LIVES);

  state_e state_q, state_d;
  lives_t lives_q, lives_d;
  logic   serve_q, serve_d;
  logic   trig_q, trig_d;
  logic   goclr_q, goclr_d;
  logic   frst_q, frst_d;
  logic   go_entry_q, go_entry_d;
  logic   start_prev_q;
  logic   start_armed_q;
  logic   start_edge;

  logic             cnt_clear;
  logic [CNT_W-1:0] cnt_limit;
  logic             cnt_done;

  // start_armed_q stays low while the button has been high continuously
  // since reset, so a button held through reset is not taken as a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_prev_q  <= 1'b0;
      start_armed_q <= !start_btn;
    end else begin
      start_prev_q  <= start_btn;
      start_armed_q <= start_armed_q || !start_btn;
    end
  end

  assign start_edge = start_btn && !start_prev_q && start_armed_q;

  assign cnt_clear = !((state_q == ST_SERVE) || (state_q == ST_GAME_OVER));
  assign cnt_limit = (state_q == ST_GAME_OVER) ? GO_LAST : SERVE_LAST;

  frame_delay_counter #(
    .CNT_W (CNT_W)
  ) u_delay (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (cnt_clear),
    .frame_tick_i (frame_tick),
    .limit_i      (cnt_limit),
    .done_o       (cnt_done)
  );

  always_comb begin
    state_d    = state_q;
    lives_d    = lives_q;
    serve_d    = 1'b0;
    trig_d     = 1'b0;
    goclr_d    = 1'b0;
    frst_d     = 1'b0;
    go_entry_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d = ST_SERVE;
          frst_d  = 1'b1;
        end
      end
      ST_SERVE: begin
        if (cnt_done) begin
          state_d = ST_PLAY;
          serve_d = 1'b1;
        end
      end
      ST_PLAY: begin
        if (bricks_cleared) begin
          state_d = ST_SERVE;
          frst_d  = 1'b1;
        end else if (ball_lost) begin
          if (lives_q > lives_t'(1)) begin
            lives_d = lives_q - lives_t'(1);
            state_d = ST_SERVE;
          end else begin
            lives_d    = '0;
            state_d    = ST_GAME_OVER;
            trig_d     = 1'b1;
            go_entry_d = 1'b1;
          end
        end
      end
      ST_GAME_OVER: begin
        // Completion seen on the entry cycle is stale from a previous game.
        if ((game_over_complete && !go_entry_q) || cnt_done) begin
          state_d = ST_CLEANUP;
          goclr_d = 1'b1;
          frst_d  = 1'b1;
          lives_d = LIVES_INIT;
        end
      end
      ST_CLEANUP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      lives_q    <= LIVES_INIT;
      serve_q    <= 1'b0;
      trig_q     <= 1'b0;
      goclr_q    <= 1'b0;
      frst_q     <= 1'b0;
      go_entry_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lives_q    <= lives_d;
      serve_q    <= serve_d;
      trig_q     <= trig_d;
      goclr_q    <= goclr_d;
      frst_q     <= frst_d;
      go_entry_q <= go_entry_d;
    end
  end

  assign play_enable       = (state_q == ST_PLAY);
  assign in_game_over      = (state_q == ST_GAME_OVER);
  assign serve_ball        = serve_q;
  assign trigger_game_over = trig_q;
  assign game_over_clear   = goclr_q;
  assign field_reset       = frst_q;
  assign lives             = lives_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Self-checking bench for game_flow_controller: a vector table for the main
// session flow plus hand-written sequences for the game-over corner cases.
module tb_game_flow_controller;

  logic       clk;
  logic       reset;
  logic       frame_tick;
  logic       start_btn;
  logic       ball_lost;
  logic       bricks_cleared;
  logic       game_over_complete;
  logic       play_enable;
  logic       serve_ball;
  logic [1:0] lives;
  logic       trigger_game_over;
  logic       game_over_clear;
  logic       field_reset;
  logic       in_game_over;

  int n_cmp;
  int n_bad;

  game_flow_controller #(
    .START_LIVES        (3),
    .SERVE_DELAY_FRAMES (60),
    .GO_TIMEOUT_FRAMES  (400)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .frame_tick         (frame_tick),
    .start_btn          (start_btn),
    .ball_lost          (ball_lost),
    .bricks_cleared     (bricks_cleared),
    .game_over_complete (game_over_complete),
    .play_enable        (play_enable),
    .serve_ball         (serve_ball),
    .lives              (lives),
    .trigger_game_over  (trigger_game_over),
    .game_over_clear    (game_over_clear),
    .field_reset        (field_reset),
    .in_game_over       (in_game_over)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Packed view: {play_enable, serve_ball, lives[1:0], trigger, clear, field_reset, in_game_over}
  logic [7:0] outs;
  assign outs = {play_enable, serve_ball, lives, trigger_game_over,
                 game_over_clear, field_reset, in_game_over};

  typedef struct {
    int         n;
    logic       r, s, b, c, g, t;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [7:0] pk(input logic pe, input logic sb, input logic [1:0] lv,
                                    input logic tg, input logic gc, input logic fr,
                                    input logic ig);
    return {pe, sb, lv, tg, gc, fr, ig};
  endfunction

  task automatic add(input int n, input logic r, input logic s, input logic b,
                     input logic c, input logic g, input logic t,
                     input logic [7:0] exp, input string name);
    vec_t v;
    v.n = n; v.r = r; v.s = s; v.b = b; v.c = c; v.g = g; v.t = t;
    v.exp = exp; v.name = name;
    tbl.push_back(v);
  endtask

  // Drive inputs for one clock, then sample 1 time unit after the edge.
  task automatic cyc(input logic r, input logic s, input logic b,
                     input logic c, input logic g, input logic t);
    reset = r; start_btn = s; ball_lost = b;
    bricks_cleared = c; game_over_complete = g; frame_tick = t;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [7:0] exp);
    n_cmp++;
    if (outs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, outs, exp);
    end
  endtask

  // From IDLE with lives=3: start, serve, lose two balls; ends in PLAY, lives=1.
  task automatic to_last_life();
    cyc(0, 1, 0, 0, 0, 0);
    check("tl_start", pk(0, 0, 2'd3, 0, 0, 1, 0));
    cyc(0, 0, 0, 0, 0, 0);
    repeat (60) cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0, 0);
    repeat (60) cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0, 0);
    repeat (60) cyc(0, 0, 0, 0, 0, 1);
    check("tl_serve_lv1", pk(1, 1, 2'd1, 0, 0, 0, 0));
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int bad_cycles;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1; start_btn = 1'b0; ball_lost = 1'b0;
    bricks_cleared = 1'b0; game_over_complete = 1'b0; frame_tick = 1'b0;

    //   n   r  s  b  c  g  t   pe sb lv tg gc fr ig
    add(1,  1, 0, 0, 0, 0, 0, pk(0, 0, 2'd3, 0, 0, 0, 0), "reset");
    add(1,  0, 1, 0, 0, 0, 0, pk(0, 0, 2'd3, 0, 0, 1, 0), "start_edge");
    add(1,  0, 1, 0, 0, 0, 0, pk(0, 0, 2'd3, 0, 0, 0, 0), "start_held");
    add(59, 0, 0, 0, 0, 0, 1, pk(0, 0, 2'd3, 0, 0, 0, 0), "serve_59");
    add(1,  0, 0, 0, 0, 0, 1, pk(1, 1, 2'd3, 0, 0, 0, 0), "serve_60");
    add(1,  0, 0, 0, 0, 0, 0, pk(1, 0, 2'd3, 0, 0, 0, 0), "play");
    add(1,  0, 0, 1, 0, 0, 0, pk(0, 0, 2'd2, 0, 0, 0, 0), "lost_3to2");
    add(59, 0, 0, 0, 0, 0, 1, pk(0, 0, 2'd2, 0, 0, 0, 0), "reserve_59");
    add(1,  0, 0, 0, 0, 0, 1, pk(1, 1, 2'd2, 0, 0, 0, 0), "reserve_60");
    add(1,  0, 0, 0, 1, 0, 0, pk(0, 0, 2'd2, 0, 0, 1, 0), "bricks_cleared");
    add(59, 0, 0, 0, 0, 0, 1, pk(0, 0, 2'd2, 0, 0, 0, 0), "bc_serve_59");
    add(1,  0, 0, 0, 0, 0, 1, pk(1, 1, 2'd2, 0, 0, 0, 0), "bc_serve_60");
    add(1,  0, 0, 1, 0, 0, 0, pk(0, 0, 2'd1, 0, 0, 0, 0), "lost_2to1");
    add(59, 0, 0, 0, 0, 0, 1, pk(0, 0, 2'd1, 0, 0, 0, 0), "s3_59");
    add(1,  0, 0, 0, 0, 0, 1, pk(1, 1, 2'd1, 0, 0, 0, 0), "s3_60");
    add(1,  0, 0, 1, 1, 0, 0, pk(0, 0, 2'd1, 0, 0, 1, 0), "lost_and_cleared");
    add(59, 0, 0, 0, 0, 0, 1, pk(0, 0, 2'd1, 0, 0, 0, 0), "s4_59");
    add(1,  0, 0, 0, 0, 0, 1, pk(1, 1, 2'd1, 0, 0, 0, 0), "s4_60");
    add(1,  0, 1, 0, 0, 1, 0, pk(1, 0, 2'd1, 0, 0, 0, 0), "play_ignores");
    add(1,  0, 0, 1, 0, 0, 0, pk(0, 0, 2'd0, 1, 0, 0, 1), "last_ball");
    add(1,  0, 0, 1, 0, 0, 0, pk(0, 0, 2'd0, 0, 0, 0, 1), "go_ignores_lost");
    add(1,  0, 0, 0, 0, 1, 0, pk(0, 0, 2'd3, 0, 1, 1, 0), "cleanup");
    add(1,  0, 0, 0, 0, 0, 0, pk(0, 0, 2'd3, 0, 0, 0, 0), "back_idle");
    add(1,  0, 1, 0, 0, 0, 0, pk(0, 0, 2'd3, 0, 0, 1, 0), "restart");
    add(1,  1, 1, 0, 0, 0, 0, pk(0, 0, 2'd3, 0, 0, 0, 0), "reset_in_serve");
    add(2,  0, 1, 0, 0, 0, 0, pk(0, 0, 2'd3, 0, 0, 0, 0), "held_thru_reset");
    add(1,  0, 0, 0, 0, 0, 0, pk(0, 0, 2'd3, 0, 0, 0, 0), "release");
    add(1,  0, 1, 0, 0, 0, 0, pk(0, 0, 2'd3, 0, 0, 1, 0), "press_again");
    add(1,  1, 0, 0, 0, 0, 0, pk(0, 0, 2'd3, 0, 0, 0, 0), "reset2");

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++)
        cyc(tbl[i].r, tbl[i].s, tbl[i].b, tbl[i].c, tbl[i].g, tbl[i].t);
      check(tbl[i].name, tbl[i].exp);
    end

    // Handshake: completion arrives 300 frames into GAME_OVER.
    to_last_life();
    cyc(0, 0, 1, 0, 0, 0);
    check("hs_trigger", pk(0, 0, 2'd0, 1, 0, 0, 1));
    bad_cycles = 0;
    for (int k = 0; k < 300; k++) begin
      cyc(0, 0, 0, 0, 0, 1);
      if (outs !== pk(0, 0, 2'd0, 0, 0, 0, 1)) bad_cycles++;
    end
    n_cmp++;
    if (bad_cycles != 0) begin
      n_bad++;
      $display("FAIL hs_wait: got %0d bad cycles want 0", bad_cycles);
    end
    cyc(0, 0, 0, 0, 1, 0);
    check("hs_complete", pk(0, 0, 2'd3, 0, 1, 1, 0));
    cyc(0, 0, 0, 0, 0, 0);
    check("hs_idle", pk(0, 0, 2'd3, 0, 0, 0, 0));

    // Stale completion held high on GAME_OVER entry is ignored for a cycle.
    to_last_life();
    cyc(0, 0, 1, 0, 1, 0);
    check("stale_trigger", pk(0, 0, 2'd0, 1, 0, 0, 1));
    cyc(0, 0, 0, 0, 1, 0);
    check("stale_ignored", pk(0, 0, 2'd0, 0, 0, 0, 1));
    cyc(0, 0, 0, 0, 1, 0);
    check("stale_then_exit", pk(0, 0, 2'd3, 0, 1, 1, 0));
    cyc(0, 0, 0, 0, 0, 0);

    // Watchdog: no completion, exit on the 400th frame.
    to_last_life();
    cyc(0, 0, 1, 0, 0, 0);
    repeat (399) cyc(0, 0, 0, 0, 0, 1);
    check("wd_399", pk(0, 0, 2'd0, 0, 0, 0, 1));
    cyc(0, 0, 0, 0, 0, 1);
    check("wd_400", pk(0, 0, 2'd3, 0, 1, 1, 0));
    cyc(0, 0, 0, 0, 0, 0);
    check("wd_idle", pk(0, 0, 2'd3, 0, 0, 0, 0));

    // Reset in GAME_OVER with start held across it.
    to_last_life();
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 0, 0);
    check("rst_go", pk(0, 0, 2'd3, 0, 0, 0, 0));
    repeat (3) cyc(0, 1, 0, 0, 0, 0);
    check("rst_held", pk(0, 0, 2'd3, 0, 0, 0, 0));
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    check("rst_repress", pk(0, 0, 2'd3, 0, 0, 1, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
